// File: rtl/brainfuck_pkg.sv
// Shared definitions for the brainfuck core and its code loader.
//   - opcode byte constants (also decoded by the core)
//   - loader FSM state encoding
//   - loader error codes
//   - is_opcode(): true for the eight executable opcode bytes
package brainfuck_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B; // +
  localparam logic [7:0] OP_DEC   = 8'h2D; // -
  localparam logic [7:0] OP_LEFT  = 8'h3C; // <
  localparam logic [7:0] OP_RIGHT = 8'h3E; // >
  localparam logic [7:0] OP_JZ    = 8'h5B; // [
  localparam logic [7:0] OP_JNZ   = 8'h5D; // ]
  localparam logic [7:0] OP_OUT   = 8'h2E; // .
  localparam logic [7:0] OP_IN    = 8'h2C; // ,
  localparam logic [7:0] OP_END   = 8'h00; // end of program

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TERM = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } loader_state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNMATCHED = 2'd2;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd3;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_INC) || (b == OP_DEC) || (b == OP_LEFT) || (b == OP_RIGHT) ||
           (b == OP_JZ)  || (b == OP_JNZ) || (b == OP_OUT)  || (b == OP_IN);
  endfunction

endpackage

// File: rtl/brainfuck_code_loader_if.sv
// Byte-stream input and code-RAM write bus of the brainfuck code loader.
//   in_data/in_valid/in_ready : program byte stream (valid/ready)
//   addr_code/dataOut_code/writeRq_code : code-RAM write port
// Modports:
//   slave  - the loader (stream sink, drives the RAM write port)
//   master - the byte source / environment side
interface brainfuck_code_loader_if #(
  parameter int addrSize = 9
) ();
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [addrSize-1:0] addr_code;
  logic [7:0]          dataOut_code;
  logic                writeRq_code;

  modport slave (
    input  in_data, in_valid,
    output in_ready, addr_code, dataOut_code, writeRq_code
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, addr_code, dataOut_code, writeRq_code
  );
endinterface

// File: rtl/brainfuck_bracket_checker.sv
// Bracket-depth tracker for the code loader.
//   clk, reset (async active-low), clr (sync clear at load start)
//   open_br   : a '[' is being stored
//   close_br  : a ']' is being considered for storage
//   underflow : close_br while depth is already 0 (combinational)
//   nonzero   : depth != 0, i.e. some '[' still unclosed
// Depth cannot wrap: it never exceeds the stored byte count, which is below 2^addrSize.
module brainfuck_bracket_checker #(
  parameter int addrSize = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic open_br,
  input  logic close_br,
  output logic underflow,
  output logic nonzero
);

  logic [addrSize-1:0] depth_q;

  assign underflow = close_br && (depth_q == '0);
  assign nonzero   = (depth_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
    end else if (clr) begin
      depth_q <= '0;
    end else if (open_br) begin
      depth_q <= depth_q + 1'b1;
    end else if (close_br && !underflow) begin
      depth_q <= depth_q - 1'b1;
    end
  end

endmodule

// File: rtl/brainfuck_code_loader.sv
// Brainfuck code loader: writes a byte-stream program into code RAM from
// address 0, appends the 0x00 terminator, checks bracket balance and holds
// the core in reset until a clean load completes.
// Ports:
//   clk, reset (async active-low), start (single-cycle load request)
//   bus        : stream input + code-RAM write port (interface, slave side)
//   core_reset : active-low core reset, high only while RUN
//   done       : load finished cleanly, core running
//   error      : 0 none, 1 overflow, 2 unmatched ']', 3 unclosed '['
//   length     : stored bytes, terminator excluded
// Build option: define FILTER_COMMENTS_EN to store only the eight opcode
// bytes; otherwise every non-terminator byte is stored verbatim.
module brainfuck_code_loader
  import brainfuck_pkg::*;
#(
  parameter int         addrSize = 9,
  parameter logic [7:0] END_CHAR = 8'h21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  brainfuck_code_loader_if.slave bus,
  output logic                  core_reset,
  output logic                  done,
  output logic [1:0]            error,
  output logic [addrSize-1:0]   length
);

  // Last slot is reserved for the terminator.
  localparam logic [addrSize-1:0] LAST_IDX = '1;

  loader_state_t       state_q, state_d;
  logic [addrSize-1:0] idx_q;
  logic [1:0]          error_q;
  logic [addrSize-1:0] addr_q;
  logic [7:0]          data_q;
  logic                wr_q;

  logic acc, is_term, keep, ovf, cand, store, start_ok;
  logic open_br, close_br, underflow, nonzero;

  always_comb begin
    is_term = (bus.in_data == OP_END) || (bus.in_data == END_CHAR);
`ifdef FILTER_COMMENTS_EN
    keep = is_opcode(bus.in_data);
`else
    keep = 1'b1;
`endif
    acc      = (state_q == ST_LOAD) && bus.in_valid;
    // Once an error is latched, bytes are swallowed until the terminator.
    ovf      = acc && !is_term && (error_q == ERR_NONE) && keep && (idx_q == LAST_IDX);
    cand     = acc && !is_term && (error_q == ERR_NONE) && keep && (idx_q != LAST_IDX);
    open_br  = cand && (bus.in_data == OP_JZ);
    close_br = cand && (bus.in_data == OP_JNZ);
    // An underflowing ']' is not written; the terminator lands in its slot.
    store    = cand && !underflow;
    start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_FAIL));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (acc && (is_term || ovf)) state_d = ST_TERM;
      ST_TERM: state_d = ((error_q != ERR_NONE) || nonzero) ? ST_FAIL : ST_RUN;
      ST_RUN:  if (start) state_d = ST_LOAD;
      ST_FAIL: if (start) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      error_q <= ERR_NONE;
      addr_q  <= '0;
      data_q  <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (start_ok) begin
        idx_q   <= '0;
        error_q <= ERR_NONE;
      end
      if (store) begin
        wr_q   <= 1'b1;
        addr_q <= idx_q;
        data_q <= bus.in_data;
        idx_q  <= idx_q + 1'b1;
      end
      if (ovf)       error_q <= ERR_OVERFLOW;
      if (underflow) error_q <= ERR_UNMATCHED;
      // Terminator write is presented during the TERM cycle.
      if ((state_q == ST_LOAD) && (state_d == ST_TERM)) begin
        wr_q   <= 1'b1;
        addr_q <= idx_q;
        data_q <= OP_END;
      end
      if ((state_q == ST_TERM) && (error_q == ERR_NONE) && nonzero)
        error_q <= ERR_UNCLOSED;
    end
  end

  brainfuck_bracket_checker #(.addrSize(addrSize)) u_brackets (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .open_br   (open_br),
    .close_br  (close_br),
    .underflow (underflow),
    .nonzero   (nonzero)
  );

  assign bus.in_ready     = (state_q == ST_LOAD);
  assign bus.addr_code    = addr_q;
  assign bus.dataOut_code = data_q;
  assign bus.writeRq_code = wr_q;
  assign core_reset       = (state_q == ST_RUN);
  assign done             = (state_q == ST_RUN);
  assign error            = error_q;
  assign length           = idx_q;

endmodule

// File: tb/tb_brainfuck_code_loader.sv
// Directed self-checking bench for brainfuck_code_loader: one instance with
// the default address width and one with addrSize=3 for the overflow case.
module tb_brainfuck_code_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start9 = 1'b0;
  logic start3 = 1'b0;
  logic core_reset9, done9, core_reset3, done3;
  logic [1:0] error9, error3;
  logic [8:0] length9;
  logic [2:0] length3;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  brainfuck_code_loader_if #(.addrSize(9)) bif9 ();
  brainfuck_code_loader_if #(.addrSize(3)) bif3 ();

  brainfuck_code_loader #(.addrSize(9), .END_CHAR(8'h21)) dut9 (
    .clk(clk), .reset(reset), .start(start9), .bus(bif9.slave),
    .core_reset(core_reset9), .done(done9), .error(error9), .length(length9)
  );

  brainfuck_code_loader #(.addrSize(3), .END_CHAR(8'h21)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bus(bif3.slave),
    .core_reset(core_reset3), .done(done3), .error(error3), .length(length3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write logs, captured mid-cycle.
  logic [8:0] a9 [64];
  logic [7:0] d9 [64];
  int         c9 [64];
  int         n9 = 0;
  logic [2:0] a3 [64];
  logic [7:0] d3 [64];
  int         n3 = 0;

  always @(negedge clk) begin
    if (bif9.writeRq_code === 1'b1 && n9 < 64) begin
      a9[n9] <= bif9.addr_code;
      d9[n9] <= bif9.dataOut_code;
      c9[n9] <= cyc;
      n9     <= n9 + 1;
    end
    if (bif3.writeRq_code === 1'b1 && n3 < 64) begin
      a3[n3] <= bif3.addr_code;
      d3[n3] <= bif3.dataOut_code;
      n3     <= n3 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send9(input logic [7:0] b);
    int k;
    bif9.in_data  = b;
    bif9.in_valid = 1'b1;
    k = 0;
    while (bif9.in_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("send9_ready", {31'd0, bif9.in_ready}, 32'd1);
    tick();
  endtask

  task automatic pulse_start9();
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
  endtask

  task automatic check_zero9(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bif9.in_ready}, 32'd0);
    chk({tag, "_wr"},       {31'd0, bif9.writeRq_code}, 32'd0);
    chk({tag, "_addr"},     {23'd0, bif9.addr_code}, 32'd0);
    chk({tag, "_data"},     {24'd0, bif9.dataOut_code}, 32'd0);
    chk({tag, "_core_rst"}, {31'd0, core_reset9}, 32'd0);
    chk({tag, "_done"},     {31'd0, done9}, 32'd0);
    chk({tag, "_error"},    {30'd0, error9}, 32'd0);
    chk({tag, "_length"},   {23'd0, length9}, 32'd0);
  endtask

  logic [7:0] exp1 [5];
  logic [7:0] exp5 [4];
  int base;

  initial begin
    bif9.in_data = 8'h00; bif9.in_valid = 1'b0;
    bif3.in_data = 8'h00; bif3.in_valid = 1'b0;
    exp1[0] = 8'h2B; exp1[1] = 8'h5B; exp1[2] = 8'h2D; exp1[3] = 8'h5D; exp1[4] = 8'h00;

    // Reset state
    tick(); tick();
    check_zero9("rst");
    chk("rst3_in_ready", {31'd0, bif3.in_ready}, 32'd0);
    chk("rst3_core_rst", {31'd0, core_reset3}, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_in_ready", {31'd0, bif9.in_ready}, 32'd0);

    // Test 1: "+[-]" 0x00 back-to-back
    pulse_start9();
    chk("t1_in_ready", {31'd0, bif9.in_ready}, 32'd1);
    base = n9;
    send9(8'h2B); send9(8'h5B); send9(8'h2D); send9(8'h5D); send9(8'h00);
    bif9.in_valid = 1'b0;
    chk("t1_term_in_ready", {31'd0, bif9.in_ready}, 32'd0);
    tick();
    chk("t1_nwrites", n9 - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_addr%0d", i), {23'd0, a9[base+i]}, i);
      chk($sformatf("t1_data%0d", i), {24'd0, d9[base+i]}, {24'd0, exp1[i]});
      chk($sformatf("t1_cyc%0d", i), c9[base+i] - c9[base], i);
    end
    chk("t1_length", {23'd0, length9}, 32'd4);
    chk("t1_done", {31'd0, done9}, 32'd1);
    chk("t1_core_rst", {31'd0, core_reset9}, 32'd1);
    chk("t1_error", {30'd0, error9}, 32'd0);
    chk("t1_run_wr", {31'd0, bif9.writeRq_code}, 32'd0);

    // Test 2: "+]" '!' -> unmatched ']'
    pulse_start9();
    chk("t2_core_rst_load", {31'd0, core_reset9}, 32'd0);
    chk("t2_done_load", {31'd0, done9}, 32'd0);
    base = n9;
    send9(8'h2B); send9(8'h5D); send9(8'h21);
    bif9.in_valid = 1'b0;
    tick();
    chk("t2_nwrites", n9 - base, 32'd2);
    chk("t2_term_addr", {23'd0, a9[base+1]}, 32'd1);
    chk("t2_term_data", {24'd0, d9[base+1]}, 32'd0);
    chk("t2_error", {30'd0, error9}, 32'd2);
    chk("t2_core_rst", {31'd0, core_reset9}, 32'd0);
    chk("t2_done", {31'd0, done9}, 32'd0);
    chk("t2_fail_in_ready", {31'd0, bif9.in_ready}, 32'd0);
    pulse_start9();
    chk("t2_restart_error", {30'd0, error9}, 32'd0);
    chk("t2_restart_ready", {31'd0, bif9.in_ready}, 32'd1);

    // Test 3: "[[>]" 0x00 -> unclosed '['
    base = n9;
    send9(8'h5B); send9(8'h5B); send9(8'h3E); send9(8'h5D); send9(8'h00);
    bif9.in_valid = 1'b0;
    chk("t3_error_term", {30'd0, error9}, 32'd0);
    tick();
    chk("t3_error", {30'd0, error9}, 32'd3);
    chk("t3_nwrites", n9 - base, 32'd5);
    chk("t3_term_addr", {23'd0, a9[base+4]}, 32'd4);
    chk("t3_term_data", {24'd0, d9[base+4]}, 32'd0);
    chk("t3_done", {31'd0, done9}, 32'd0);

    // Test 4: addrSize=3, eight '+' -> overflow
    start3 = 1'b1; tick(); start3 = 1'b0;
    bif3.in_data = 8'h2B; bif3.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_ready%0d", i), {31'd0, bif3.in_ready}, 32'd1);
      tick();
    end
    bif3.in_valid = 1'b0;
    chk("t4_ready_after", {31'd0, bif3.in_ready}, 32'd0);
    tick();
    chk("t4_nwrites", n3, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_addr%0d", i), {29'd0, a3[i]}, i);
      chk($sformatf("t4_data%0d", i), {24'd0, d3[i]}, (i < 7) ? 32'h2B : 32'h00);
    end
    chk("t4_error", {30'd0, error3}, 32'd1);
    chk("t4_length", {29'd0, length3}, 32'd7);
    chk("t4_core_rst", {31'd0, core_reset3}, 32'd0);

    // Test 5: "a+b" 0x00, valid every other cycle
    pulse_start9();
    base = n9;
    send9(8'h61); bif9.in_valid = 1'b0; tick();
    send9(8'h2B); bif9.in_valid = 1'b0; tick();
    send9(8'h62); bif9.in_valid = 1'b0; tick();
    send9(8'h00); bif9.in_valid = 1'b0;
    tick();
`ifdef FILTER_COMMENTS_EN
    exp5[0] = 8'h2B; exp5[1] = 8'h00; exp5[2] = 8'h00; exp5[3] = 8'h00;
    chk("t5_nwrites", n9 - base, 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t5_addr%0d", i), {23'd0, a9[base+i]}, i);
      chk($sformatf("t5_data%0d", i), {24'd0, d9[base+i]}, {24'd0, exp5[i]});
    end
    chk("t5_length", {23'd0, length9}, 32'd1);
`else
    exp5[0] = 8'h61; exp5[1] = 8'h2B; exp5[2] = 8'h62; exp5[3] = 8'h00;
    chk("t5_nwrites", n9 - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_addr%0d", i), {23'd0, a9[base+i]}, i);
      chk($sformatf("t5_data%0d", i), {24'd0, d9[base+i]}, {24'd0, exp5[i]});
    end
    chk("t5_length", {23'd0, length9}, 32'd3);
`endif
    chk("t5_done", {31'd0, done9}, 32'd1);
    chk("t5_error", {30'd0, error9}, 32'd0);

    // Test 6: async reset mid-LOAD, then empty-program reload
    pulse_start9();
    send9(8'h2B); send9(8'h2B);
    #2;
    reset = 1'b0;
    #1;
    check_zero9("t6");
    bif9.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    pulse_start9();
    base = n9;
    send9(8'h00);
    bif9.in_valid = 1'b0;
    tick();
    chk("t6_nwrites", n9 - base, 32'd1);
    chk("t6_addr", {23'd0, a9[base]}, 32'd0);
    chk("t6_data", {24'd0, d9[base]}, 32'd0);
    chk("t6_length", {23'd0, length9}, 32'd0);
    chk("t6_done", {31'd0, done9}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/brainfuck_code_loader.md
Name: brainfuck_code_loader

Overview:
Writer side of the brainfuck core's code-RAM interface. Accepts a program as a byte stream (valid/ready, e.g. from a UART receiver) and writes it into code RAM from address 0. It appends the 0x00 terminator that the core treats as end-of-program, and checks bracket balance. It holds the core in reset while loading and releases it only after a clean load.

Parameters:
addrSize, 9, code-RAM address width; capacity DEPTH = 2^addrSize bytes, including the terminator slot.
END_CHAR, 8'h21, in-band end-of-program byte ('!'); 8'h00 also terminates.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle load request
in_data  in  8  program byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte this cycle
addr_code  out  addrSize  code-RAM write address
dataOut_code  out  8  code-RAM write data
writeRq_code  out  1  code-RAM write strobe; one byte per cycle
core_reset  out  1  active-low reset to the core; 0 = core held
done  out  1  load completed cleanly; core running
error  out  2  0 none, 1 overflow, 2 unmatched ']', 3 unclosed '['
length  out  addrSize  stored bytes, excluding the terminator

Behaviour:
- Reset (asynchronous, active-low): state IDLE. All outputs 0: in_ready, writeRq_code, addr_code, dataOut_code, core_reset, done, error, length. Bracket depth 0.
- States: IDLE, LOAD, TERM, RUN, FAIL.
- IDLE: core_reset=0. start -> LOAD. Clears addr, length, depth and error; done=0.
- LOAD: in_ready=1 every cycle; throughput 1 byte/clk. Transfer occurs on in_valid&in_ready.
  - Terminator byte (0x00 or END_CHAR): not stored -> TERM.
  - Stored byte: dataOut_code=byte, writeRq_code=1, addr_code=current write index on the next cycle (1-cycle registered latency). Index and length then increment.
  - '[' increments depth. ']' at depth 0 latches error=2; otherwise it decrements depth.
  - Stored byte when index == DEPTH-1: byte dropped, error=1 latched, in_ready=0 -> TERM. The last slot is always reserved for 0x00.
  - Once any error is latched: later bytes are consumed but not written, until a terminator arrives. Exception: overflow goes straight to TERM.
  - Only the first error is latched.
- TERM (1 cycle): writes 0x00 at the current index; in_ready=0.
  - If no error is latched and depth != 0, sets error=3.
  - Next state: error==0 -> RUN, else FAIL.
- RUN: core_reset=1, done=1, in_ready=0, writeRq_code=0. start -> LOAD, with core_reset=0 in that same next cycle.
- FAIL: core_reset=0, error held, in_ready=0. start -> LOAD (clears error).
- writeRq_code is never high outside the cycle following an accept, or the TERM write.
- start while in LOAD or TERM is ignored.
- Depth counter is addrSize bits wide; it cannot overflow because depth <= stored bytes < DEPTH.
- Empty program (terminator first): writes 0x00 at addr 0, length=0 -> RUN.

Optional Feature:
FILTER_COMMENTS_EN
- Defined: only the eight opcode bytes + - < > [ ] . , are stored. All other non-terminator bytes are accepted (in_ready=1) and discarded; they do not count toward length or overflow.
- Undefined: every non-terminator byte is stored verbatim; the core skips comments itself.

Decomposition:
- Shared package brainfuck_pkg:
  - opcode constants (8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C, 8'h00);
  - loader state encoding;
  - error code constants.
- Opcode constants are reused by the core.
- One natural sub-module: brainfuck_bracket_checker. It holds the depth counter and produces the underflow and nonzero-at-end flags.

Test Plan:
1. start; stream "+[-]" then 0x00, back-to-back -> writes 2B,5B,2D,5D,00 at addr 0..4, one per cycle; length=4; done=1; core_reset=1; error=0.
2. Stream "+]" then '!' -> error=2, FAIL state, core_reset=0, 0x00 written at addr 1. A following start returns to LOAD with error=0.
3. Stream "[[>]" then 0x00 -> error=3 after TERM; 0x00 written at addr 4.
4. addrSize=3; stream 8 '+' bytes -> 7 written (addr 0..6), 8th dropped, error=1, 0x00 at addr 7, in_ready falls in the cycle after the 8th accept.
5. Stream "a+b" then 0x00 with in_valid toggling every other cycle:
   - FILTER_COMMENTS_EN defined -> only 2B stored, length=1.
   - Undefined -> 61,2B,62 stored, length=3.
6. Assert reset low mid-LOAD, asynchronously between clock edges -> all outputs 0 immediately, state IDLE; a later start reloads from addr 0.
